// File: rtl/uart_tx_engine.sv
// uart_tx_engine
//   Transmit side of the UART. Bytes written through TBR/tx_flag are queued in
//   a small FIFO and serialised onto tx as start / data / optional parity /
//   stop bits. The line format is set by LCR. The bit rate is set by the
//   divisor {DLH,DLL}.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-high
//   tx_flag      one-cycle pulse: push TBR into the FIFO
//   TBR[7:0]     byte to transmit, sampled when tx_flag=1
//   LCR[7:0]     [1:0] word length 5..8, [2] two stop bits, [3] parity enable,
//                [4] even parity, [6] break (force tx low)
//   DLL[7:0]     divisor low byte
//   DLH[7:0]     divisor high byte
//   tx           serial output, idle high, registered
//   tx_busy      frame in progress
//   tx_empty     nothing queued and nothing being sent
//   tx_full      FIFO holds FIFO_DEPTH entries
//   tx_overflow  one-cycle pulse: a push was dropped because the FIFO was full
module uart_tx_engine #(
  parameter int FIFO_DEPTH = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_flag,
  input  logic [7:0] TBR,
  input  logic [7:0] LCR,
  input  logic [7:0] DLL,
  input  logic [7:0] DLH,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_empty,
  output logic       tx_full,
  output logic       tx_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PRE_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state, next_state;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  logic [7:0]  data_sh;
  logic [4:0]  lcr_sh;
  logic [15:0] div_sh;

  logic [PRE_W-1:0] pre_cnt;
  logic [15:0]      div_cnt;
  logic [2:0]       bit_idx;
  logic             stop_cnt;

  logic        fifo_full, fifo_nonempty;
  logic        bit_done, last_data, last_stop, frame_end;
  logic        pop, push_ok, overflow_next;
  logic [15:0] div_in;
  logic [7:0]  data_masked;
  logic        parity_bit;
  logic        tx_next;
  logic        unused_lcr;

  assign unused_lcr = ^{LCR[7], LCR[5]};

  assign fifo_full     = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_nonempty = (count != '0);

  // A bit ends after OVERSAMPLE prescaler ticks times DIV divisor ticks.
  assign bit_done  = (pre_cnt == PRE_W'(OVERSAMPLE - 1)) && (div_cnt == div_sh - 16'd1);
  // The last data bit index is 4 + LCR[1:0], i.e. {1, wl}.
  assign last_data = (bit_idx == {1'b1, lcr_sh[1:0]});
  assign last_stop = !lcr_sh[2] || stop_cnt;
  assign frame_end = (state == STOP) && bit_done && last_stop;

  // The head is popped either from IDLE or on the very cycle the last stop bit
  // ends, so that queued frames follow each other without an idle gap.
  assign pop           = fifo_nonempty && ((state == IDLE) || frame_end);
  assign push_ok       = tx_flag && (!fifo_full || pop);
  assign overflow_next = tx_flag && fifo_full && !pop;

  assign div_in      = ({DLH, DLL} == 16'd0) ? 16'd1 : {DLH, DLL};
  assign data_masked = data_sh & (8'hFF >> (2'd3 - lcr_sh[1:0]));
  assign parity_bit  = lcr_sh[4] ? ^data_masked : ~^data_masked;

  // FIFO storage has no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= TBR;
    end
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Shadow copies of the byte and line configuration for the frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_sh <= '0;
      lcr_sh  <= '0;
      div_sh  <= 16'd1;
    end else if (pop) begin
      data_sh <= mem[rd_ptr];
      lcr_sh  <= LCR[4:0];
      div_sh  <= div_in;
    end
  end

  // Two-level bit timer. It is held at zero in IDLE and wraps on every bit
  // boundary, so each state entry starts a fresh, exact bit time.
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE) || bit_done) begin
      pre_cnt <= '0;
      div_cnt <= '0;
    end else if (pre_cnt == PRE_W'(OVERSAMPLE - 1)) begin
      pre_cnt <= '0;
      div_cnt <= div_cnt + 16'd1;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  // Data bit index and stop bit counter. Both are cleared outside their own state.
  always_ff @(posedge clk) begin
    if (rst || (state != DATA)) begin
      bit_idx <= '0;
    end else if (bit_done) begin
      bit_idx <= bit_idx + 3'd1;
    end
    if (rst || (state != STOP)) begin
      stop_cnt <= 1'b0;
    end else if (bit_done) begin
      stop_cnt <= ~stop_cnt;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and next line level.
  always_comb begin
    next_state = state;
    tx_next    = 1'b1;
    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (fifo_nonempty) begin
          next_state = START;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (bit_done) begin
          next_state = DATA;
        end
      end
      DATA: begin
        tx_next = data_sh[bit_idx];
        if (bit_done && last_data) begin
          next_state = lcr_sh[3] ? PARITY : STOP;
        end
      end
      PARITY: begin
        tx_next = parity_bit;
        if (bit_done) begin
          next_state = STOP;
        end
      end
      STOP: begin
        tx_next = 1'b1;
        if (frame_end) begin
          next_state = fifo_nonempty ? START : IDLE;
        end
      end
      default: begin
        next_state = IDLE;
        tx_next    = 1'b1;
      end
    endcase
    if (LCR[6]) begin
      tx_next = 1'b0;
    end
  end

  // tx and the overflow pulse are registered to keep the outputs glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx          <= 1'b1;
      tx_overflow <= 1'b0;
    end else begin
      tx          <= tx_next;
      tx_overflow <= overflow_next;
    end
  end

  assign tx_busy  = (state != IDLE);
  assign tx_empty = !fifo_nonempty && (state == IDLE);
  assign tx_full  = fifo_full;

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine
//   Directed bench for uart_tx_engine. Inputs are driven and outputs sampled on
//   the falling clock edge. Frame bits are checked at the centre of each bit
//   time. Frame lengths are checked via the tx_busy fall.
module tb_uart_tx_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_flag = 1'b0;
  logic [7:0] TBR = 8'h00;
  logic [7:0] LCR = 8'h03;
  logic [7:0] DLL = 8'h01;
  logic [7:0] DLH = 8'h00;
  logic       tx, tx_busy, tx_empty, tx_full, tx_overflow;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  uart_tx_engine #(.FIFO_DEPTH(16), .OVERSAMPLE(16)) dut (
    .clk(clk),
    .rst(rst),
    .tx_flag(tx_flag),
    .TBR(TBR),
    .LCR(LCR),
    .DLL(DLL),
    .DLH(DLH),
    .tx(tx),
    .tx_busy(tx_busy),
    .tx_empty(tx_empty),
    .tx_full(tx_full),
    .tx_overflow(tx_overflow)
  );

  always #5 clk = ~clk;

  // Count of rising edges so far; used to place samples at exact cycles.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called on a falling edge; holds tx_flag for exactly one rising edge.
  task automatic applyStimulus(input logic [7:0] b);
    tx_flag = 1'b1;
    TBR     = b;
    @(negedge clk);
    tx_flag = 1'b0;
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic waitFall(input string tag, output int fall);
    bit found;
    found = 1'b0;
    fall  = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    fall = cyc;
    checkOutput({tag, "_fall_seen"}, 32'(found), 32'd1);
  endtask

  // Builds the expected line sequence from the frame format and checks each bit
  // at its centre, plus the very first cycle of the start bit.
  task automatic checkBits(input string tag, input logic [7:0] data, input int nbits,
                           input bit par_en, input bit even, input int stops,
                           input int bt, input int fall);
    logic seq [12];
    int   len;
    logic p;
    len = 0;
    seq[len] = 1'b0;
    len++;
    p = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      seq[len] = data[i];
      len++;
      p = p ^ data[i];
    end
    if (par_en) begin
      seq[len] = even ? p : ~p;
      len++;
    end
    for (int i = 0; i < stops; i++) begin
      seq[len] = 1'b1;
      len++;
    end
    waitUntil(fall);
    checkOutput({tag, "_start_edge"}, 32'(tx), 32'd0);
    for (int j = 0; j < len; j++) begin
      waitUntil(fall + bt / 2 + j * bt);
      checkOutput($sformatf("%s_bit%0d", tag, j), 32'(tx), 32'(seq[j]));
    end
  endtask

  // tx_busy must still be high on the last cycle of the frame and low right after.
  task automatic checkEnd(input string tag, input int fall, input int frame_len);
    waitUntil(fall + frame_len - 2);
    checkOutput({tag, "_busy_last"}, 32'(tx_busy), 32'd1);
    waitUntil(fall + frame_len - 1);
    checkOutput({tag, "_busy_end"}, 32'(tx_busy), 32'd0);
    checkOutput({tag, "_empty_end"}, 32'(tx_empty), 32'd1);
    checkOutput({tag, "_tx_end"}, 32'(tx), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int f, f0, c;

    // T1: reset
    repeat (2) @(negedge clk);
    checkOutput("t1_tx", 32'(tx), 32'd1);
    checkOutput("t1_empty", 32'(tx_empty), 32'd1);
    checkOutput("t1_busy", 32'(tx_busy), 32'd0);
    checkOutput("t1_full", 32'(tx_full), 32'd0);
    checkOutput("t1_ovf", 32'(tx_overflow), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // T2: 8N1, divisor 1, byte 0x55, exact start latency
    LCR = 8'h03;
    DLL = 8'h01;
    DLH = 8'h00;
    applyStimulus(8'h55);
    checkOutput("t2_nonempty", 32'(tx_empty), 32'd0);
    checkOutput("t2_idle_e0", 32'(tx_busy), 32'd0);
    checkOutput("t2_tx_e0", 32'(tx), 32'd1);
    @(negedge clk);
    checkOutput("t2_tx_e1", 32'(tx), 32'd1);
    checkOutput("t2_busy_e1", 32'(tx_busy), 32'd1);
    @(negedge clk);
    checkOutput("t2_tx_e2", 32'(tx), 32'd0);
    f = cyc;
    checkBits("t2", 8'h55, 8, 1'b0, 1'b0, 1, 16, f);
    checkEnd("t2", f, 160);

    // T3: 8 bits, even parity, one stop
    LCR = 8'h1B;
    applyStimulus(8'h07);
    c = cyc;
    waitFall("t3", f);
    checkOutput("t3_latency", 32'(f - c), 32'd2);
    checkBits("t3", 8'h07, 8, 1'b1, 1'b1, 1, 16, f);
    checkEnd("t3", f, 176);

    // T4: 5 bits, two stops, divisor 2
    LCR = 8'h04;
    DLL = 8'h02;
    applyStimulus(8'hFF);
    waitFall("t4", f);
    checkBits("t4", 8'hFF, 5, 1'b0, 1'b0, 2, 32, f);
    checkEnd("t4", f, 256);

    // Break forces the line low one cycle after it is set
    LCR = 8'h43;
    @(negedge clk);
    checkOutput("brk_low", 32'(tx), 32'd0);
    LCR = 8'h03;
    @(negedge clk);
    checkOutput("brk_release", 32'(tx), 32'd1);

    // T5: 18 back-to-back pushes; byte 0x11 hits a full FIFO and is dropped
    DLL = 8'h01;
    f0 = 0;
    fork
      begin
        for (int k = 0; k < 18; k++) begin
          applyStimulus(8'(k));
          if (k == 15) checkOutput("t5_full_k15", 32'(tx_full), 32'd0);
          if (k == 16) begin
            checkOutput("t5_full_k16", 32'(tx_full), 32'd1);
            checkOutput("t5_ovf_k16", 32'(tx_overflow), 32'd0);
          end
          if (k == 17) checkOutput("t5_ovf_k17", 32'(tx_overflow), 32'd1);
        end
        @(negedge clk);
        checkOutput("t5_ovf_after", 32'(tx_overflow), 32'd0);
        checkOutput("t5_full_after", 32'(tx_full), 32'd1);
      end
      begin
        waitFall("t5_0", f0);
        checkBits("t5_0", 8'h00, 8, 1'b0, 1'b0, 1, 16, f0);
      end
    join
    for (int k = 1; k < 17; k++) begin
      checkBits($sformatf("t5_%0d", k), 8'(k), 8, 1'b0, 1'b0, 1, 16, f0 + k * 160);
    end
    checkEnd("t5", f0 + 16 * 160, 160);
    checkOutput("t5_full_end", 32'(tx_full), 32'd0);

    // T6: reset during data bit 3 aborts the frame and flushes the FIFO
    applyStimulus(8'hA5);
    applyStimulus(8'h77);
    waitFall("t6a", f);
    waitUntil(f + 16 * 4 + 8);
    checkOutput("t6_pre", 32'(tx), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t6_tx", 32'(tx), 32'd1);
    checkOutput("t6_empty", 32'(tx_empty), 32'd1);
    checkOutput("t6_busy", 32'(tx_busy), 32'd0);
    checkOutput("t6_full", 32'(tx_full), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(8'h3C);
    waitFall("t6b", f);
    checkBits("t6b", 8'h3C, 8, 1'b0, 1'b0, 1, 16, f);
    checkEnd("t6b", f, 160);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
